// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-side bundle for bram_port_arbiter.
// Per-port fields are flat vectors; port i sits at [i*W +: W].
// The master side holds the requesters and the BRAM macro; the slave side is the arbiter.
interface bram_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*STRB_WIDTH-1:0] req_we;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wrdata;
  logic [NUM_PORTS-1:0]            rsp_valid;
  logic [NUM_PORTS-1:0]            rsp_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_data;
  logic                            bram_en;
  logic [STRB_WIDTH-1:0]           bram_we;
  logic [ADDR_WIDTH-1:0]           bram_addr;
  logic [DATA_WIDTH-1:0]           bram_wrdata;
  logic [DATA_WIDTH-1:0]           bram_rddata;

  modport master (
    output req_valid, req_addr, req_we, req_wrdata, rsp_ready, bram_rddata,
    input  req_ready, rsp_valid, rsp_data, bram_en, bram_we, bram_addr, bram_wrdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wrdata, rsp_ready, bram_rddata,
    output req_ready, rsp_valid, rsp_data, bram_en, bram_we, bram_addr, bram_wrdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM (1-cycle read latency)
// among NUM_PORTS valid/ready requesters, one access per cycle.
// Each port owns a one-entry response slot: LIVE passes bram_rddata straight
// through, HELD replays a captured copy while the consumer back-pressures.
// Optional: define BRAM_PORT_ARBITER_STATS_EN to add per-port stall counters (stall_cnt).
module bram_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic clk,
  input  logic rstn,
  bram_port_arbiter_if.slave bus
`ifdef BRAM_PORT_ARBITER_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0] stall_cnt
`endif
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_LIVE, SLOT_HELD} slot_e;

  logic [NUM_PORTS-1:0] w_elig, w_grant, w_rsp_valid;
  logic [PTR_W-1:0]     r_ptr, w_gidx;
  logic                 w_any;
  int                   w_idx;

  // A port may take a new request only if its slot is free or drains this cycle.
  // Gating with rstn keeps req_ready/bram_en low for the whole reset.
  assign w_elig = bus.req_valid & ~(w_rsp_valid & ~bus.rsp_ready) & {NUM_PORTS{rstn}};

  // Round-robin pick: first eligible port scanning from r_ptr with wraparound.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_any   = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
      if (!w_any && w_elig[w_idx]) begin
        w_any          = 1'b1;
        w_gidx         = w_idx[PTR_W-1:0];
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = w_rsp_valid;

  // Steer the granted port's command onto the BRAM; idle cycles drive zeros.
  always_comb begin
    bus.bram_en     = w_any;
    bus.bram_we     = '0;
    bus.bram_addr   = '0;
    bus.bram_wrdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_grant[i]) begin
        bus.bram_we     = bus.req_we[i*STRB_WIDTH +: STRB_WIDTH];
        bus.bram_addr   = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.bram_wrdata = bus.req_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Priority pointer moves just past the last winner; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_ptr <= '0;
    else if (w_any) r_ptr <= (w_gidx == PTR_W'(NUM_PORTS - 1)) ? '0 : w_gidx + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
    slot_e                 r_slot, w_slot_nxt;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_hold, w_live;

    // Write responses carry zero data; reads carry the BRAM output.
    assign w_live              = r_wr ? '0 : bus.bram_rddata;
    assign w_rsp_valid[gi]     = (r_slot != SLOT_EMPTY);
    assign bus.rsp_data[gi*DATA_WIDTH +: DATA_WIDTH] = (r_slot == SLOT_HELD) ? r_hold : w_live;

    // Slot state register.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_slot <= SLOT_EMPTY;
      else       r_slot <= w_slot_nxt;
    end

    // Slot transitions; a grant always lands the slot in LIVE.
    always_comb begin
      w_slot_nxt = r_slot;
      case (r_slot)
        SLOT_EMPTY: if (w_grant[gi]) w_slot_nxt = SLOT_LIVE;
        SLOT_LIVE:  if (w_grant[gi])           w_slot_nxt = SLOT_LIVE;
                    else if (bus.rsp_ready[gi]) w_slot_nxt = SLOT_EMPTY;
                    else                        w_slot_nxt = SLOT_HELD;
        SLOT_HELD:  if (w_grant[gi])           w_slot_nxt = SLOT_LIVE;
                    else if (bus.rsp_ready[gi]) w_slot_nxt = SLOT_EMPTY;
        default:    w_slot_nxt = SLOT_EMPTY;
      endcase
    end

    // Remember read/write kind at accept; capture the live word when it would be lost.
    always_ff @(posedge clk) begin
      if (w_grant[gi]) r_wr <= |bus.req_we[gi*STRB_WIDTH +: STRB_WIDTH];
      if (r_slot == SLOT_LIVE && !bus.rsp_ready[gi]) r_hold <= w_live;
    end

`ifdef BRAM_PORT_ARBITER_STATS_EN
    logic [31:0] r_stall;
    // Count cycles a port asks but is not served, saturating at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_stall <= '0;
      else if (bus.req_valid[gi] && !w_grant[gi] && r_stall != 32'hFFFF_FFFF)
        r_stall <= r_stall + 32'd1;
    end
    assign stall_cnt[gi*32 +: 32] = r_stall;
`endif
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a write-first BRAM model.
module tb_bram_port_arbiter;
  localparam int NP = 2, DW = 64, AW = 16, SW = DW / 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_pass = 0, n_total = 0;

  bram_port_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif();
`ifdef BRAM_PORT_ARBITER_STATS_EN
  logic [NP*32-1:0] stall_cnt;
`endif

  bram_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bif)
`ifdef BRAM_PORT_ARBITER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Write-first BRAM model; contents reload to known values while in reset.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 64'h0000_0000_0000_A5A5;
      mem[8'h20] = 64'hDEAD_BEEF_0000_0020;
      bif.bram_rddata <= '0;
    end else if (bif.bram_en) begin
      for (int b = 0; b < SW; b++)
        if (bif.bram_we[b]) mem[bif.bram_addr[7:0]][b*8 +: 8] = bif.bram_wrdata[b*8 +: 8];
      bif.bram_rddata <= mem[bif.bram_addr[7:0]];
    end
  end

  task automatic set_req(input int p, input logic v, input logic [AW-1:0] a,
                         input logic [SW-1:0] we, input logic [DW-1:0] d);
    bif.req_valid[p]          = v;
    bif.req_addr[p*AW +: AW]  = a;
    bif.req_we[p*SW +: SW]    = we;
    bif.req_wrdata[p*DW +: DW] = d;
  endtask

  task automatic clear_inputs;
    bif.req_valid = '0; bif.req_addr = '0; bif.req_we = '0; bif.req_wrdata = '0;
    bif.rsp_ready = 2'b11;
  endtask

  task automatic apply_reset;
    @(negedge clk); rstn = 1'b0; clear_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; clear_inputs(); bif.req_valid = 2'b11;
    @(negedge clk); #1;
    n_total++; if (bif.req_ready !== 2'b00) $display("FAIL rst_req_ready got %b exp 00", bif.req_ready); else n_pass++;
    n_total++; if (bif.bram_en !== 1'b0) $display("FAIL rst_bram_en got %b exp 0", bif.bram_en); else n_pass++;
    n_total++; if (bif.bram_we !== '0) $display("FAIL rst_bram_we got %h exp 0", bif.bram_we); else n_pass++;
    n_total++; if (bif.rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid got %b exp 00", bif.rsp_valid); else n_pass++;
    bif.req_valid = '0;
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_single_read;
    apply_reset();
    @(negedge clk); set_req(0, 1'b1, 16'h10, '0, '0); #1;
    n_total++; if (bif.req_ready !== 2'b01) $display("FAIL rd_req_ready got %b exp 01", bif.req_ready); else n_pass++;
    n_total++; if (bif.bram_en !== 1'b1 || bif.bram_addr !== 16'h10) $display("FAIL rd_bram_cmd got en=%b addr=%h exp en=1 addr=0010", bif.bram_en, bif.bram_addr); else n_pass++;
    @(negedge clk); set_req(0, 1'b0, '0, '0, '0); #1;
    n_total++; if (bif.rsp_valid !== 2'b01) $display("FAIL rd_rsp_valid got %b exp 01", bif.rsp_valid); else n_pass++;
    n_total++; if (bif.rsp_data[63:0] !== 64'hA5A5) $display("FAIL rd_rsp_data got %h exp a5a5", bif.rsp_data[63:0]); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (bif.rsp_valid !== 2'b00) $display("FAIL rd_rsp_drain got %b exp 00", bif.rsp_valid); else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [NP-1:0] exp_g [4];
    logic [NP-1:0] exp_v [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_v = '{2'b00, 2'b01, 2'b10, 2'b01};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_req(0, 1'b1, 16'h10, '0, '0); set_req(1, 1'b1, 16'h20, '0, '0); #1;
      n_total++; if (bif.req_ready !== exp_g[c] || bif.bram_en !== 1'b1) $display("FAIL rr_grant c%0d got %b en=%b exp %b en=1", c, bif.req_ready, bif.bram_en, exp_g[c]); else n_pass++;
      n_total++; if (bif.rsp_valid !== exp_v[c]) $display("FAIL rr_rsp_valid c%0d got %b exp %b", c, bif.rsp_valid, exp_v[c]); else n_pass++;
      if (c == 1) begin
        n_total++; if (bif.rsp_data[63:0] !== 64'hA5A5) $display("FAIL rr_data0 got %h exp a5a5", bif.rsp_data[63:0]); else n_pass++;
      end
      if (c == 2) begin
        n_total++; if (bif.rsp_data[127:64] !== 64'hDEAD_BEEF_0000_0020) $display("FAIL rr_data1 got %h exp deadbeef00000020", bif.rsp_data[127:64]); else n_pass++;
      end
    end
    @(negedge clk); clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_write_read;
    apply_reset();
    @(negedge clk); set_req(0, 1'b1, 16'h3, 8'h0F, 64'h1122_3344); #1;
    n_total++; if (bif.req_ready !== 2'b01 || bif.bram_we !== 8'h0F || bif.bram_wrdata !== 64'h1122_3344)
      $display("FAIL wr_cmd got rdy=%b we=%h wd=%h exp 01 0f 11223344", bif.req_ready, bif.bram_we, bif.bram_wrdata); else n_pass++;
    @(negedge clk); set_req(0, 1'b1, 16'h3, '0, '0); #1;
    n_total++; if (bif.rsp_valid !== 2'b01 || bif.rsp_data[63:0] !== '0) $display("FAIL wr_rsp got v=%b d=%h exp 01 0", bif.rsp_valid, bif.rsp_data[63:0]); else n_pass++;
    n_total++; if (bif.req_ready !== 2'b01 || bif.bram_we !== '0) $display("FAIL wr_then_rd got rdy=%b we=%h exp 01 00", bif.req_ready, bif.bram_we); else n_pass++;
    @(negedge clk); set_req(0, 1'b0, '0, '0, '0); #1;
    n_total++; if (bif.rsp_valid !== 2'b01 || bif.rsp_data[63:0] !== 64'h1122_3344) $display("FAIL wr_readback got v=%b d=%h exp 01 11223344", bif.rsp_valid, bif.rsp_data[63:0]); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_held;
    apply_reset();
    @(negedge clk); set_req(1, 1'b1, 16'h20, '0, '0); bif.rsp_ready = 2'b01; #1;
    n_total++; if (bif.req_ready !== 2'b10) $display("FAIL hold_first got %b exp 10", bif.req_ready); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); set_req(0, 1'b1, 16'h10, '0, '0); #1;
      n_total++; if (bif.req_ready !== 2'b01) $display("FAIL hold_grant c%0d got %b exp 01", c, bif.req_ready); else n_pass++;
      n_total++; if (bif.rsp_valid[1] !== 1'b1 || bif.rsp_data[127:64] !== 64'hDEAD_BEEF_0000_0020)
        $display("FAIL hold_data c%0d got v=%b d=%h exp 1 deadbeef00000020", c, bif.rsp_valid[1], bif.rsp_data[127:64]); else n_pass++;
      if (c == 1) begin
        n_total++; if (bif.rsp_valid !== 2'b11 || bif.rsp_data[63:0] !== 64'hA5A5) $display("FAIL hold_p0_served got v=%b d=%h exp 11 a5a5", bif.rsp_valid, bif.rsp_data[63:0]); else n_pass++;
      end
    end
    @(negedge clk); bif.rsp_ready = 2'b11; #1;
    n_total++; if (bif.req_ready !== 2'b10) $display("FAIL hold_release got %b exp 10", bif.req_ready); else n_pass++;
    n_total++; if (bif.rsp_data[127:64] !== 64'hDEAD_BEEF_0000_0020) $display("FAIL hold_last got %h exp deadbeef00000020", bif.rsp_data[127:64]); else n_pass++;
    @(negedge clk); clear_inputs(); #1;
    n_total++; if (bif.rsp_valid !== 2'b10 || bif.rsp_data[127:64] !== 64'hDEAD_BEEF_0000_0020)
      $display("FAIL hold_regrant got v=%b d=%h exp 10 deadbeef00000020", bif.rsp_valid, bif.rsp_data[127:64]); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    apply_reset();
    @(negedge clk); set_req(0, 1'b1, 16'h10, '0, '0);
    @(negedge clk); clear_inputs(); bif.rsp_ready = 2'b00; #1;
    n_total++; if (bif.rsp_valid !== 2'b01) $display("FAIL mid_pre got %b exp 01", bif.rsp_valid); else n_pass++;
    #1; rstn = 1'b0; bif.req_valid = 2'b11; #1;
    n_total++; if (bif.rsp_valid !== 2'b00 || bif.req_ready !== 2'b00 || bif.bram_en !== 1'b0)
      $display("FAIL mid_in_reset got v=%b r=%b en=%b exp 00 00 0", bif.rsp_valid, bif.req_ready, bif.bram_en); else n_pass++;
    @(negedge clk); rstn = 1'b1; bif.rsp_ready = 2'b11; #1;
    n_total++; if (bif.rsp_valid !== 2'b00) $display("FAIL mid_stale got %b exp 00", bif.rsp_valid); else n_pass++;
    n_total++; if (bif.req_ready !== 2'b01) $display("FAIL mid_ptr0 got %b exp 01", bif.req_ready); else n_pass++;
    @(negedge clk); clear_inputs(); #1;
    n_total++; if (bif.rsp_valid !== 2'b01) $display("FAIL mid_after got %b exp 01", bif.rsp_valid); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (bif.rsp_valid !== 2'b00) $display("FAIL mid_drain got %b exp 00", bif.rsp_valid); else n_pass++;
  endtask

`ifdef BRAM_PORT_ARBITER_STATS_EN
  task automatic test_stats;
    apply_reset();
    @(negedge clk); set_req(1, 1'b1, 16'h20, '0, '0); bif.rsp_ready = 2'b01;
    repeat (5) begin
      @(negedge clk); set_req(0, 1'b1, 16'h10, '0, '0);
    end
    @(negedge clk); clear_inputs(); #1;
    n_total++; if (stall_cnt[63:32] !== 32'd5) $display("FAIL stats_p1 got %0d exp 5", stall_cnt[63:32]); else n_pass++;
    n_total++; if (stall_cnt[31:0] !== 32'd0) $display("FAIL stats_p0 got %0d exp 0", stall_cnt[31:0]); else n_pass++;
    @(negedge clk);
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_read();
    test_held();
    test_reset_mid();
`ifdef BRAM_PORT_ARBITER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
